dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the CPU load/store request interface.
- Accepts one request at a time from the pipeline's memory stage, with a valid/ready handshake.
- Models a configurable access latency and returns a response, read data for loads and acknowledge for stores, through a second valid/ready handshake.
- Backing store is a little-endian byte array; accesses are 1, 2, 4 or 8 bytes.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 209 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bus between the pipeline memory stage (master)
// and the data-memory responder (slave). Both handshakes are valid/ready.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [3:0]  req_size;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, performs the access on the edge into RESP and holds the response
// until the requester takes it.
// Backing store is split into eight byte lanes (one RAM per lane). Every
// legal access is naturally aligned, so it never spans two 8-byte words and
// one word index addresses all lanes.
// Optional macro DMEM_ALIGN_CHECK_EN: instead of normalising size/address,
// flag misaligned, out-of-range or badly sized requests with rsp_err.
module dmem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave io_bus
);

  localparam int CW    = $clog2(LATENCY + 1);
  localparam int WIDX  = (ADDR_BITS > 3) ? ADDR_BITS - 3 : 1;
  localparam int WORDS = (ADDR_BITS > 3) ? (1 << (ADDR_BITS - 3)) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;

  logic        r_write;
  logic [63:0] r_addr;
  logic [3:0]  r_size;
  logic [63:0] r_wdata;

  // log2 of the effective transfer size; unsupported sizes behave as 8 bytes
  function automatic logic [1:0] size_lg(input logic [3:0] size);
    case (size)
      4'd1:    return 2'd0;
      4'd2:    return 2'd1;
      4'd4:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] lg);
    case (lg)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] data_mask(input logic [1:0] lg);
    case (lg)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // With LATENCY==1 the access happens on the accept edge itself, so it must
  // use the live request rather than the copy being latched on that edge.
  logic        w_src_write;
  logic [63:0] w_src_addr;
  logic [3:0]  w_src_size;
  logic [63:0] w_src_wdata;
  assign w_src_write = (LATENCY == 1) ? io_bus.req_write : r_write;
  assign w_src_addr  = (LATENCY == 1) ? io_bus.req_addr  : r_addr;
  assign w_src_size  = (LATENCY == 1) ? io_bus.req_size  : r_size;
  assign w_src_wdata = (LATENCY == 1) ? io_bus.req_wdata : r_wdata;

  logic w_accept, w_commit;
  assign w_accept = (r_state == S_IDLE) && io_bus.req_valid;
  // Reset on the commit edge cancels the access.
  assign w_commit = !reset &&
                    ((LATENCY == 1) ? w_accept : ((r_state == S_WAIT) && (r_cnt == CW'(1))));

  logic [1:0]      w_src_lg;
  logic [2:0]      w_src_off;
  logic [7:0]      w_be;
  logic [63:0]     w_wshift;
  logic [WIDX-1:0] w_widx;
  assign w_src_lg  = size_lg(w_src_size);
  assign w_src_off = w_src_addr[2:0] & (3'b111 << w_src_lg);
  assign w_be      = lane_mask(w_src_lg) << w_src_off;
  assign w_wshift  = w_src_wdata << {w_src_off, 3'b000};
  assign w_widx    = (ADDR_BITS > 3) ? WIDX'(w_src_addr >> 3) : '0;

  logic w_src_err;
  logic w_err_q;

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_err;
  logic w_bad_size, w_misalign, w_out_of_range;

  // Fault detection on the raw request; no normalisation in this build
  always_comb begin
    w_bad_size     = !(w_src_size inside {4'd1, 4'd2, 4'd4, 4'd8});
    w_misalign     = (w_src_addr & {60'd0, w_src_size - 4'd1}) != 64'd0;
    w_out_of_range = (w_src_addr >> ADDR_BITS) != 64'd0;
    w_src_err      = w_bad_size || w_misalign || w_out_of_range;
  end

  // Fault flag captured with the access and held through RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_commit) begin
      r_err <= w_src_err;
    end
  end

  assign w_err_q = r_err;
`else
  assign w_src_err = 1'b0;
  assign w_err_q   = 1'b0;
`endif

  logic w_we;
  assign w_we = w_commit && w_src_write && !w_src_err;

  logic [63:0] w_rd_word;

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] r_mem [WORDS];
    logic [7:0] r_rd_byte;

    // Byte-lane RAM: masked write and registered read, both on the commit edge
    always_ff @(posedge clk) begin
      if (w_we && w_be[gi]) begin
        r_mem[w_widx] <= w_wshift[8*gi +: 8];
      end
      if (w_commit) begin
        r_rd_byte <= r_mem[w_widx];
      end
    end

    assign w_rd_word[8*gi +: 8] = r_rd_byte;
  end

  // Next-state and counter logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (io_bus.req_valid) begin
          w_cnt_next   = CW'(LATENCY - 1);
          w_state_next = (LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - CW'(1);
        if (r_cnt <= CW'(1)) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (io_bus.rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and latency counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Request capture on acceptance
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      r_write <= io_bus.req_write;
      r_addr  <= io_bus.req_addr;
      r_size  <= io_bus.req_size;
      r_wdata <= io_bus.req_wdata;
    end
  end

  // Load data: pick the addressed bytes out of the read word, zero-extended
  logic [1:0]  w_out_lg;
  logic [2:0]  w_out_off;
  logic [63:0] w_rd_shift;
  logic        w_in_resp;
  assign w_out_lg   = size_lg(r_size);
  assign w_out_off  = r_addr[2:0] & (3'b111 << w_out_lg);
  assign w_rd_shift = w_rd_word >> {w_out_off, 3'b000};
  assign w_in_resp  = (r_state == S_RESP);

  assign io_bus.req_ready = (r_state == S_IDLE);
  assign io_bus.rsp_valid = w_in_resp;
  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.rsp_err   = w_in_resp && w_err_q;
  assign io_bus.rsp_rdata = (w_in_resp && !r_write && !w_err_q) ?
                            (w_rd_shift & data_mask(w_out_lg)) : 64'd0;

  // Address bits above the array and the LATENCY==1 copies are not always consumed
  logic w_unused;
  assign w_unused = ^{w_src_addr, r_addr, r_wdata};

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a byte-array reference model.
// Main instance runs LATENCY=3; a second instance checks LATENCY=1 issue rate.
module tb_dmem_responder;
  localparam int AB    = 10;
  localparam int LAT   = 3;
  localparam int MEMSZ = 1 << AB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus0();
  dmem_responder_if bus1();

  dmem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .io_bus(bus0)
  );

  dmem_responder #(.ADDR_BITS(AB), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .io_bus(bus1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;
  logic [7:0] mem_model [MEMSZ];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int norm_n(input logic [3:0] size);
    if (size == 4'd1 || size == 4'd2 || size == 4'd4 || size == 4'd8) return int'(size);
    return 8;
  endfunction

  function automatic logic model_fault(input logic [63:0] addr, input logic [3:0] size);
`ifdef DMEM_ALIGN_CHECK_EN
    if (!(size == 4'd1 || size == 4'd2 || size == 4'd4 || size == 4'd8)) return 1'b1;
    if ((addr % 64'(size)) != 64'd0) return 1'b1;
    if (addr >= 64'(MEMSZ)) return 1'b1;
    return 1'b0;
`else
    return (addr == 64'd0) && (size == 4'd15) && 1'b0;
`endif
  endfunction

  function automatic logic [63:0] model_read(input int a, input int n);
    logic [63:0] r = 64'd0;
    for (int k = 0; k < n; k++) r = r | (64'(mem_model[a + k]) << (8 * k));
    return r;
  endfunction

  // One complete transaction on the main instance, starting and ending at a negedge
  task automatic do_req(input logic wr, input logic [63:0] addr, input logic [3:0] size,
                        input logic [63:0] wdata, input int hold, input string tag,
                        output logic [63:0] got);
    int n, a, lat, waited;
    logic flt;
    logic [63:0] exp_rd;

    n   = norm_n(size);
    flt = model_fault(addr, size);
    a   = int'(addr % 64'(MEMSZ));
    a   = a - (a % n);
    exp_rd = 64'd0;
    if (!flt) begin
      if (wr) begin
        for (int k = 0; k < n; k++) mem_model[a + k] = 8'(wdata >> (8 * k));
      end else begin
        exp_rd = model_read(a, n);
      end
    end

    waited = 0;
    while (!bus0.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " req_ready"}, 64'(bus0.req_ready), 64'd1);

    bus0.req_valid = 1'b1;
    bus0.req_write = wr;
    bus0.req_addr  = addr;
    bus0.req_size  = size;
    bus0.req_wdata = wdata;
    bus0.rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    bus0.req_addr  = {$urandom, $urandom};
    bus0.req_wdata = {$urandom, $urandom};

    lat = 1;
    while (!bus0.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(LAT));
    got = bus0.rsp_rdata;
    check({tag, " rdata"}, bus0.rsp_rdata, exp_rd);
    check({tag, " err"}, 64'(bus0.rsp_err), 64'(flt));

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold valid"}, 64'(bus0.rsp_valid), 64'd1);
      check({tag, " hold rdata"}, bus0.rsp_rdata, exp_rd);
      check({tag, " hold req_ready"}, 64'(bus0.req_ready), 64'd0);
    end

    bus0.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.rsp_ready = 1'b0;
    check({tag, " done valid"}, 64'(bus0.rsp_valid), 64'd0);
    check({tag, " done req_ready"}, 64'(bus0.req_ready), 64'd1);
    check({tag, " done rdata"}, bus0.rsp_rdata, 64'd0);
    check({tag, " done busy"}, 64'(bus0.busy), 64'd0);

    n_txn++;
    $display("txn %0d %s %s addr=%h size=%0d wdata=%h rdata=%h err=%0d",
             n_txn, tag, wr ? "ST" : "LD", addr, size, wdata, got, flt);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [63:0] got, prior, d1;
    logic [3:0]  sizes [10];
    logic        wr;
    logic [63:0] addr;

    sizes = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0};

    reset = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0;
    bus0.req_size  = 4'd8; bus0.req_wdata = '0;   bus0.rsp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0;
    bus1.req_size  = 4'd8; bus1.req_wdata = '0;   bus1.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset req_ready", 64'(bus0.req_ready), 64'd1);
    check("reset rsp_valid", 64'(bus0.rsp_valid), 64'd0);
    check("reset rsp_rdata", bus0.rsp_rdata, 64'd0);
    check("reset rsp_err", 64'(bus0.rsp_err), 64'd0);
    check("reset busy", 64'(bus0.busy), 64'd0);

    // Give the whole array known contents
    for (int i = 0; i < MEMSZ / 8; i++) begin
      do_req(1'b1, 64'(i * 8), 4'd8, {$urandom, $urandom}, 0, "fill", got);
    end

    do_req(1'b1, 64'h10, 4'd8, 64'h1122334455667788, 0, "st64", got);
    check("st64 ack rdata", got, 64'd0);
    do_req(1'b0, 64'h10, 4'd8, 64'd0, 0, "ld64", got);
    check("ld64 value", got, 64'h1122334455667788);
    do_req(1'b1, 64'h13, 4'd1, 64'hFF, 0, "st8", got);
    do_req(1'b0, 64'h10, 4'd8, 64'd0, 0, "ld64b", got);
    check("ld64b value", got, 64'h11223344FF667788);
    do_req(1'b0, 64'h13, 4'd1, 64'd0, 5, "ld8 bp", got);
    check("ld8 value", got, 64'h00000000000000FF);

    // Reset one cycle after accepting a store: the store must not land
    prior = model_read(32'h20, 2);
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 64'h20;
    bus0.req_size  = 4'd2; bus0.req_wdata = 64'hAAAA;
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    check("midrst busy", 64'(bus0.busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst req_ready", 64'(bus0.req_ready), 64'd1);
    check("midrst rsp_valid", 64'(bus0.rsp_valid), 64'd0);
    check("midrst rdata", bus0.rsp_rdata, 64'd0);
    check("midrst err", 64'(bus0.rsp_err), 64'd0);
    check("midrst busy idle", 64'(bus0.busy), 64'd0);
    repeat (4) @(negedge clk);
    check("midrst no rsp", 64'(bus0.rsp_valid), 64'd0);
    do_req(1'b0, 64'h20, 4'd2, 64'd0, 0, "midrst ld", got);
    check("midrst prior", got, prior);

    // Misaligned store, then the aligned word it lands on (or not)
    do_req(1'b1, 64'h21, 4'd4, 64'hDEADBEEF, 0, "mis st", got);
    prior = model_read(32'h20, 4);
    do_req(1'b0, 64'h20, 4'd4, 64'd0, 0, "mis ld", got);
`ifdef DMEM_ALIGN_CHECK_EN
    check("mis ld value", got, prior);
`else
    check("mis ld value", got, 64'hDEADBEEF);
`endif

    // Random mix
    for (int t = 0; t < 80; t++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 64'($urandom_range(0, MEMSZ - 1));
      if ($urandom_range(0, 7) == 0) addr = addr | ({32'($urandom), 32'd0});
      do_req(wr, addr, sizes[$urandom_range(0, 9)], {$urandom, $urandom},
             $urandom_range(0, 2), "rand", got);
    end

    // LATENCY=1 instance, rsp_ready tied high, back-to-back requests
    d1 = {$urandom, $urandom};
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 64'h8;
    bus1.req_size  = 4'd8; bus1.req_wdata = d1;
    check("l1 c0 busy", 64'(bus1.busy), 64'd0);
    check("l1 c0 req_ready", 64'(bus1.req_ready), 64'd1);
    @(negedge clk);
    check("l1 c1 valid", 64'(bus1.rsp_valid), 64'd1);
    check("l1 c1 busy", 64'(bus1.busy), 64'd1);
    check("l1 c1 req_ready", 64'(bus1.req_ready), 64'd0);
    check("l1 c1 rdata", bus1.rsp_rdata, 64'd0);
    bus1.req_write = 1'b0;
    @(negedge clk);
    check("l1 c2 valid", 64'(bus1.rsp_valid), 64'd0);
    check("l1 c2 busy", 64'(bus1.busy), 64'd0);
    @(negedge clk);
    check("l1 c3 valid", 64'(bus1.rsp_valid), 64'd1);
    check("l1 c3 rdata", bus1.rsp_rdata, d1);
    bus1.req_addr = 64'hC; bus1.req_size = 4'd4;
    @(negedge clk);
    check("l1 c4 busy", 64'(bus1.busy), 64'd0);
    @(negedge clk);
    check("l1 c5 valid", 64'(bus1.rsp_valid), 64'd1);
    check("l1 c5 rdata", bus1.rsp_rdata, {32'd0, d1[63:32]});
    bus1.req_valid = 1'b0;
    @(negedge clk);
    check("l1 end busy", 64'(bus1.busy), 64'd0);
    check("l1 end valid", 64'(bus1.rsp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
